// File: rtl/decode_stage_hz.sv
// ---------------------------------------------------------------------------
// decode_stage_hz
//
// Instruction-decode stage of the pipelined RISC-V core. It contains:
//   - the architectural register file (NREGS x XLEN) with a same-cycle
//     write-through bypass from writeback,
//   - the control decoder (lw, sw, R-type, I-ALU, beq, jal, lui),
//   - the five-format immediate generator (I, S, B, J, U),
//   - the ID/EX pipeline register with stall (hold), flush (bubble),
//     valid tracking and illegal-instruction flagging.
//
// Parameters:
//   XLEN  : datapath width, 32 or 64
//   NREGS : architectural registers, 32 or 16 (RV32E)
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   stall_d, flush_e          hazard-unit controls (flush beats stall)
//   valid_d, instr_d          incoming instruction and its valid bit
//   pc_d, pc_plus4_d          incoming PC and PC+4
//   reg_write_w, rd_w,
//   result_w                  writeback port into the register file
//   valid_e, illegal_e        ID/EX status
//   reg_write_e, alu_src_e,
//   mem_write_e, branch_e,
//   jump_e, result_src_e,
//   alu_control_e             ID/EX control fields
//   rd1_e, rd2_e, imm_ext_e,
//   pc_e, pc_plus4_e          ID/EX data fields
//   rd_e, rs1_e, rs2_e        ID/EX register indices
// ---------------------------------------------------------------------------
module decode_stage_hz #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_d,
  input  logic            flush_e,
  input  logic            valid_d,
  input  logic [31:0]     instr_d,
  input  logic [XLEN-1:0] pc_d,
  input  logic [XLEN-1:0] pc_plus4_d,
  input  logic            reg_write_w,
  input  logic [4:0]      rd_w,
  input  logic [XLEN-1:0] result_w,
  output logic            valid_e,
  output logic            reg_write_e,
  output logic            alu_src_e,
  output logic            mem_write_e,
  output logic            branch_e,
  output logic            jump_e,
  output logic [1:0]      result_src_e,
  output logic [2:0]      alu_control_e,
  output logic            illegal_e,
  output logic [XLEN-1:0] rd1_e,
  output logic [XLEN-1:0] rd2_e,
  output logic [XLEN-1:0] imm_ext_e,
  output logic [XLEN-1:0] pc_e,
  output logic [XLEN-1:0] pc_plus4_e,
  output logic [4:0]      rd_e,
  output logic [4:0]      rs1_e,
  output logic [4:0]      rs2_e
);

  localparam int AW = $clog2(NREGS);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_IALU = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef struct packed {
    logic            valid;
    logic            reg_write;
    logic            alu_src;
    logic            mem_write;
    logic            branch;
    logic            jump;
    logic            illegal;
    logic [1:0]      result_src;
    logic [2:0]      alu_control;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm_ext;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
  } idex_t;

  // A 6-bit compare keeps NREGS=32 representable.
  function automatic logic in_range(input logic [4:0] idx);
    return ({1'b0, idx} < 6'(NREGS));
  endfunction

  // -------------------------------------------------------------------------
  // Instruction fields
  // -------------------------------------------------------------------------
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rs1_dec;
  logic [4:0] rs2_dec;

  assign opcode  = instr_d[6:0];
  assign funct3  = instr_d[14:12];
  assign funct7  = instr_d[31:25];
  // lui has no rs1; bits [19:15] are immediate and must not be treated as an
  // index (they would otherwise create false hazards downstream).
  assign rs1_dec = (opcode == OP_LUI) ? 5'd0 : instr_d[19:15];
  assign rs2_dec = instr_d[24:20];

  // -------------------------------------------------------------------------
  // Register file. Reset clears every entry, so it is built from flops.
  // -------------------------------------------------------------------------
  logic [XLEN-1:0] regs [NREGS];
  logic            wr_en;

  assign wr_en = reg_write_w && (rd_w != 5'd0) && in_range(rd_w);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[rd_w[AW-1:0]] <= result_w;
    end
  end

  // Two read ports. A write to the same register in this cycle is forwarded
  // so the ID/EX capture on this edge already sees the new value.
  logic [1:0][4:0]      rs_idx;
  logic [1:0][XLEN-1:0] rs_data;

  assign rs_idx[0] = rs1_dec;
  assign rs_idx[1] = rs2_dec;

  for (genvar gi = 0; gi < 2; gi++) begin : g_read
    logic live;
    logic hit;
    assign live        = (rs_idx[gi] != 5'd0) && in_range(rs_idx[gi]);
    assign hit         = wr_en && (rd_w == rs_idx[gi]);
    assign rs_data[gi] = !live ? '0 :
                         hit   ? result_w : regs[rs_idx[gi][AW-1:0]];
  end

  // -------------------------------------------------------------------------
  // Immediate generator, all formats sign-extended from instr[31]
  // -------------------------------------------------------------------------
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_b;
  logic [XLEN-1:0] imm_j;
  logic [XLEN-1:0] imm_u;

  assign imm_i = XLEN'($signed(instr_d[31:20]));
  assign imm_s = XLEN'($signed({instr_d[31:25], instr_d[11:7]}));
  assign imm_b = XLEN'($signed({instr_d[31], instr_d[7], instr_d[30:25],
                                instr_d[11:8], 1'b0}));
  assign imm_j = XLEN'($signed({instr_d[31], instr_d[19:12], instr_d[20],
                                instr_d[30:21], 1'b0}));
  assign imm_u = XLEN'($signed({instr_d[31:12], 12'b0}));

  // -------------------------------------------------------------------------
  // ALU function decode shared by R-type and I-ALU
  // -------------------------------------------------------------------------
  logic [2:0] alu_funct;
  logic       funct_bad;

  always_comb begin
    alu_funct = ALU_ADD;
    funct_bad = 1'b0;
    case (funct3)
      3'b000:  alu_funct = (opcode == OP_R && funct7[5]) ? ALU_SUB : ALU_ADD;
      3'b010:  alu_funct = ALU_SLT;
      3'b110:  alu_funct = ALU_OR;
      3'b111:  alu_funct = ALU_AND;
      default: funct_bad = 1'b1;
    endcase
    // Only funct7 = 0100000 (sub) is allowed besides all-zero, and only on add.
    if (opcode == OP_R &&
        !(funct7 == 7'b0000000 || (funct7 == 7'b0100000 && funct3 == 3'b000))) begin
      funct_bad = 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Control decoder
  // -------------------------------------------------------------------------
  idex_t dec;
  idex_t idex_next;
  idex_t idex_reg;
  logic  use_rs1;
  logic  use_rs2;
  logic  use_rd;
  logic  bad;

  always_comb begin
    dec          = '0;
    use_rs1      = 1'b0;
    use_rs2      = 1'b0;
    use_rd       = 1'b0;
    bad          = 1'b0;
    dec.valid    = 1'b1;
    dec.rd       = instr_d[11:7];
    dec.rs1      = rs1_dec;
    dec.rs2      = rs2_dec;
    dec.rd1      = rs_data[0];
    dec.rd2      = rs_data[1];
    dec.pc       = pc_d;
    dec.pc_plus4 = pc_plus4_d;

    case (opcode)
      OP_LW: begin
        dec.reg_write  = 1'b1;
        dec.alu_src    = 1'b1;
        dec.result_src = 2'b01;
        dec.imm_ext    = imm_i;
        use_rs1        = 1'b1;
        use_rd         = 1'b1;
      end
      OP_SW: begin
        dec.alu_src    = 1'b1;
        dec.mem_write  = 1'b1;
        dec.imm_ext    = imm_s;
        use_rs1        = 1'b1;
        use_rs2        = 1'b1;
      end
      OP_R: begin
        dec.reg_write   = 1'b1;
        dec.alu_control = alu_funct;
        bad             = funct_bad;
        use_rs1         = 1'b1;
        use_rs2         = 1'b1;
        use_rd          = 1'b1;
      end
      OP_IALU: begin
        dec.reg_write   = 1'b1;
        dec.alu_src     = 1'b1;
        dec.alu_control = alu_funct;
        dec.imm_ext     = imm_i;
        bad             = funct_bad;
        use_rs1         = 1'b1;
        use_rd          = 1'b1;
      end
      OP_BEQ: begin
        dec.branch      = 1'b1;
        dec.alu_control = ALU_SUB;
        dec.imm_ext     = imm_b;
        bad             = (funct3 != 3'b000);
        use_rs1         = 1'b1;
        use_rs2         = 1'b1;
      end
      OP_JAL: begin
        dec.reg_write  = 1'b1;
        dec.jump       = 1'b1;
        dec.result_src = 2'b10;
        dec.imm_ext    = imm_j;
        use_rd         = 1'b1;
      end
      OP_LUI: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.imm_ext   = imm_u;
        use_rd        = 1'b1;
      end
      default: bad = 1'b1;
    endcase

    // Only fields the instruction actually uses can make it illegal; an
    // immediate that happens to sit in the rs2 slot is not an index.
    dec.illegal = bad ||
                  (use_rs1 && !in_range(dec.rs1)) ||
                  (use_rs2 && !in_range(dec.rs2)) ||
                  (use_rd  && !in_range(dec.rd));

    // An illegal instruction still travels down the pipe (for the trap) but
    // must not change architectural or control-flow state.
    if (dec.illegal) begin
      dec.reg_write = 1'b0;
      dec.mem_write = 1'b0;
      dec.branch    = 1'b0;
      dec.jump      = 1'b0;
    end
  end

  // A non-valid slot is loaded as a bubble, exactly like a flush.
  assign idex_next = valid_d ? dec : '0;

  // -------------------------------------------------------------------------
  // ID/EX register: rst > flush_e > stall_d > load
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idex_reg <= '0;
    end else if (flush_e) begin
      idex_reg <= '0;
    end else if (!stall_d) begin
      idex_reg <= idex_next;
    end
  end

  assign valid_e       = idex_reg.valid;
  assign reg_write_e   = idex_reg.reg_write;
  assign alu_src_e     = idex_reg.alu_src;
  assign mem_write_e   = idex_reg.mem_write;
  assign branch_e      = idex_reg.branch;
  assign jump_e        = idex_reg.jump;
  assign result_src_e  = idex_reg.result_src;
  assign alu_control_e = idex_reg.alu_control;
  assign illegal_e     = idex_reg.illegal;
  assign rd1_e         = idex_reg.rd1;
  assign rd2_e         = idex_reg.rd2;
  assign imm_ext_e     = idex_reg.imm_ext;
  assign pc_e          = idex_reg.pc;
  assign pc_plus4_e    = idex_reg.pc_plus4;
  assign rd_e          = idex_reg.rd;
  assign rs1_e         = idex_reg.rs1;
  assign rs2_e         = idex_reg.rs2;

endmodule

// File: tb/tb_decode_stage_hz.sv
// ---------------------------------------------------------------------------
// tb_decode_stage_hz
//
// Drives a 32-bit/32-register decode stage with directed and random
// instructions and compares every ID/EX field against a reference model.
// A second instance (XLEN=64, NREGS=16) shares the stimulus and is used for
// the wide-immediate and out-of-range-register cases.
// ---------------------------------------------------------------------------
module tb_decode_stage_hz;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_d = 1'b0;
  logic        flush_e = 1'b0;
  logic        valid_d = 1'b0;
  logic [31:0] instr_d = '0;
  logic [31:0] pc_d = '0;
  logic [31:0] pc_plus4_d;
  logic        reg_write_w = 1'b0;
  logic [4:0]  rd_w = '0;
  logic [31:0] result_w = '0;

  assign pc_plus4_d = pc_d + 32'd4;

  always #5 clk = ~clk;

  // Instance 1 outputs (XLEN=32, NREGS=32)
  logic        valid_e, reg_write_e, alu_src_e, mem_write_e, branch_e, jump_e, illegal_e;
  logic [1:0]  result_src_e;
  logic [2:0]  alu_control_e;
  logic [31:0] rd1_e, rd2_e, imm_ext_e, pc_e, pc_plus4_e;
  logic [4:0]  rd_e, rs1_e, rs2_e;

  // Instance 2 outputs (XLEN=64, NREGS=16)
  logic        valid_e2, reg_write_e2, alu_src_e2, mem_write_e2, branch_e2, jump_e2, illegal_e2;
  logic [1:0]  result_src_e2;
  logic [2:0]  alu_control_e2;
  logic [63:0] rd1_e2, rd2_e2, imm_ext_e2, pc_e2, pc_plus4_e2;
  logic [4:0]  rd_e2, rs1_e2, rs2_e2;

  decode_stage_hz #(.XLEN(32), .NREGS(32)) dut (
    .clk(clk), .rst(rst), .stall_d(stall_d), .flush_e(flush_e), .valid_d(valid_d),
    .instr_d(instr_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d),
    .reg_write_w(reg_write_w), .rd_w(rd_w), .result_w(result_w),
    .valid_e(valid_e), .reg_write_e(reg_write_e), .alu_src_e(alu_src_e),
    .mem_write_e(mem_write_e), .branch_e(branch_e), .jump_e(jump_e),
    .result_src_e(result_src_e), .alu_control_e(alu_control_e), .illegal_e(illegal_e),
    .rd1_e(rd1_e), .rd2_e(rd2_e), .imm_ext_e(imm_ext_e), .pc_e(pc_e),
    .pc_plus4_e(pc_plus4_e), .rd_e(rd_e), .rs1_e(rs1_e), .rs2_e(rs2_e)
  );

  decode_stage_hz #(.XLEN(64), .NREGS(16)) dut_w (
    .clk(clk), .rst(rst), .stall_d(stall_d), .flush_e(flush_e), .valid_d(valid_d),
    .instr_d(instr_d), .pc_d({32'd0, pc_d}), .pc_plus4_d({32'd0, pc_plus4_d}),
    .reg_write_w(reg_write_w), .rd_w(rd_w), .result_w({32'd0, result_w}),
    .valid_e(valid_e2), .reg_write_e(reg_write_e2), .alu_src_e(alu_src_e2),
    .mem_write_e(mem_write_e2), .branch_e(branch_e2), .jump_e(jump_e2),
    .result_src_e(result_src_e2), .alu_control_e(alu_control_e2), .illegal_e(illegal_e2),
    .rd1_e(rd1_e2), .rd2_e(rd2_e2), .imm_ext_e(imm_ext_e2), .pc_e(pc_e2),
    .pc_plus4_e(pc_plus4_e2), .rd_e(rd_e2), .rs1_e(rs1_e2), .rs2_e(rs2_e2)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_txn    = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h (txn %0d)", tag, got, exp, n_txn);
    end
  endtask

  // -------------------------------------------------------------------------
  // Reference model: architectural register values plus the expected ID/EX
  // contents for the 32-bit instance.
  // -------------------------------------------------------------------------
  typedef struct packed {
    bit        valid, rw, asrc, mw, br, jp, ill;
    bit [1:0]  rsrc;
    bit [2:0]  alu;
    bit [31:0] rd1, rd2, imm, pc, pc4;
    bit [4:0]  rd, rs1, rs2;
  } exp_t;

  exp_t      cur;
  bit [31:0] rf [32];

  function automatic exp_t model_decode(bit [31:0] ins, bit [31:0] pc);
    exp_t    e;
    bit [6:0] op = ins[6:0];
    bit [2:0] f3 = ins[14:12];
    bit [6:0] f7 = ins[31:25];
    bit [31:0] i_imm = {{20{ins[31]}}, ins[31:20]};
    bit [31:0] s_imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    bit [31:0] b_imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    bit [31:0] j_imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    bit [31:0] u_imm = {ins[31:12], 12'd0};
    bit [2:0]  falu = 3'b000;
    bit        fbad = 0;
    e = '0;
    e.valid = 1;
    e.rd  = ins[11:7];
    e.rs1 = (op == 7'b0110111) ? 5'd0 : ins[19:15];
    e.rs2 = ins[24:20];
    e.pc  = pc;
    e.pc4 = pc + 32'd4;
    if      (f3 == 3'b000) falu = (op == 7'b0110011 && f7 == 7'h20) ? 3'b001 : 3'b000;
    else if (f3 == 3'b010) falu = 3'b101;
    else if (f3 == 3'b110) falu = 3'b011;
    else if (f3 == 3'b111) falu = 3'b010;
    else fbad = 1;
    case (op)
      7'b0000011: begin e.rw = 1; e.asrc = 1; e.rsrc = 2'b01; e.imm = i_imm; end
      7'b0100011: begin e.asrc = 1; e.mw = 1; e.imm = s_imm; end
      7'b0110011: begin
        e.rw = 1; e.alu = falu;
        e.ill = fbad || !(f7 == 7'h00 || (f7 == 7'h20 && f3 == 3'b000));
      end
      7'b0010011: begin e.rw = 1; e.asrc = 1; e.alu = falu; e.imm = i_imm; e.ill = fbad; end
      7'b1100011: begin e.br = 1; e.alu = 3'b001; e.imm = b_imm; e.ill = (f3 != 3'b000); end
      7'b1101111: begin e.rw = 1; e.jp = 1; e.rsrc = 2'b10; e.imm = j_imm; end
      7'b0110111: begin e.rw = 1; e.asrc = 1; e.imm = u_imm; end
      default:    e.ill = 1;
    endcase
    if (e.ill) begin e.rw = 0; e.mw = 0; e.br = 0; e.jp = 0; end
    // Register values as seen after this cycle's writeback (bypass).
    e.rd1 = rf[e.rs1];
    e.rd2 = rf[e.rs2];
    return e;
  endfunction

  task automatic model_edge();
    if (reg_write_w && rd_w != 5'd0) rf[rd_w] = result_w;
    if (flush_e)       cur = '0;
    else if (!stall_d) cur = valid_d ? model_decode(instr_d, pc_d) : '0;
  endtask

  task automatic compare_all();
    check("valid_e",     valid_e,     cur.valid);
    check("illegal_e",   illegal_e,   cur.ill);
    check("reg_write_e", reg_write_e, cur.rw);
    check("mem_write_e", mem_write_e, cur.mw);
    check("branch_e",    branch_e,    cur.br);
    check("jump_e",      jump_e,      cur.jp);
    check("rd1_e",       rd1_e,       cur.rd1);
    check("rd2_e",       rd2_e,       cur.rd2);
    check("pc_e",        pc_e,        cur.pc);
    check("pc_plus4_e",  pc_plus4_e,  cur.pc4);
    check("rd_e",        rd_e,        cur.rd);
    check("rs1_e",       rs1_e,       cur.rs1);
    check("rs2_e",       rs2_e,       cur.rs2);
    if (!cur.ill) begin
      check("alu_src_e",     alu_src_e,     cur.asrc);
      check("result_src_e",  result_src_e,  cur.rsrc);
      check("alu_control_e", alu_control_e, cur.alu);
      check("imm_ext_e",     imm_ext_e,     cur.imm);
    end
  endtask

  task automatic drive(input bit [31:0] ins, input bit v, input bit st, input bit fl,
                       input bit rw, input bit [4:0] rdw, input bit [31:0] res);
    instr_d = ins; valid_d = v; stall_d = st; flush_e = fl;
    reg_write_w = rw; rd_w = rdw; result_w = res;
    pc_d = pc_d + 32'd4;
  endtask

  // One clock: DUT and model update on the edge, outputs sampled 1 ns later.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
    $display("txn %0d instr=%08h v=%0d st=%0d fl=%0d wb=%0d/x%0d valid_e=%0d ill_e=%0d",
             n_txn, instr_d, valid_d, stall_d, flush_e, reg_write_w, rd_w, valid_e, illegal_e);
    n_txn++;
    @(negedge clk);
  endtask

  function automatic bit [31:0] gen_instr();
    bit [31:0] r = $urandom;
    bit [2:0]  f3s [4];
    int        k = $urandom_range(0, 9);
    f3s[0] = 3'b000; f3s[1] = 3'b010; f3s[2] = 3'b110; f3s[3] = 3'b111;
    case (k)
      0: r[6:0] = 7'b0000011;
      1: r[6:0] = 7'b0100011;
      2, 3: begin
        r[6:0]   = 7'b0110011;
        r[14:12] = f3s[$urandom_range(0, 3)];
        r[31:25] = (r[14:12] == 3'b000 && r[30]) ? 7'h20 : 7'h00;
      end
      4: begin r[6:0] = 7'b0010011; if (r[31]) r[14:12] = f3s[$urandom_range(0, 3)]; end
      5: begin r[6:0] = 7'b1100011; if (r[30]) r[14:12] = 3'b000; end
      6: r[6:0] = 7'b1101111;
      7: r[6:0] = 7'b0110111;
      8: r[6:0] = 7'b0110011;
      default: ;
    endcase
    return r;
  endfunction

  initial begin
    cur = '0;
    for (int i = 0; i < 32; i++) rf[i] = '0;

    // Power-on reset.
    repeat (2) @(negedge clk);
    #1;
    check("por_valid_e", valid_e, 0);
    check("por_rd1_e",   rd1_e,   0);
    rst = 1'b0;

    // addi x1,x0,-3 while writing x5 = 0x55.
    drive(32'hFFD00093, 1, 0, 0, 1, 5'd5, 32'h55);
    step();
    check("addi_reg_write", reg_write_e, 1);
    check("addi_alu_src",   alu_src_e,   1);
    check("addi_imm",       imm_ext_e,   32'hFFFFFFFD);
    check("addi_rd",        rd_e,        1);
    check("addi_alu",       alu_control_e, 3'b000);
    check("addi_valid",     valid_e,     1);

    // Asynchronous reset in mid-cycle with a write pending.
    drive(32'hFFD00093, 1, 1, 0, 1, 5'd5, 32'h99);
    rst = 1'b1;
    #1;
    cur = '0;
    for (int i = 0; i < 32; i++) rf[i] = '0;
    check("rst_valid_e",   valid_e,   0);
    check("rst_reg_write", reg_write_e, 0);
    check("rst_imm",       imm_ext_e, 0);
    check("rst_pc",        pc_e,      0);
    check("rst_w_valid",   valid_e2,  0);
    @(posedge clk);
    #1;
    compare_all();
    @(negedge clk);
    rst = 1'b0;

    // add x6,x5,x0: x5 was cleared by reset.
    drive(32'h00028333, 1, 0, 0, 0, 5'd0, 32'h0);
    step();
    check("x5_after_rst", rd1_e, 0);

    // Bypass: add x3,x2,x2 while x2 is written.
    drive(32'h002101B3, 1, 0, 0, 1, 5'd2, 32'h1234);
    step();
    check("bypass_rd1", rd1_e, 32'h1234);
    check("bypass_rd2", rd2_e, 32'h1234);

    // Write to x0 is discarded.
    drive(32'h000001B3, 1, 0, 0, 1, 5'd0, 32'hFF);
    step();
    drive(32'h000001B3, 1, 0, 0, 0, 5'd0, 32'h0);
    step();
    check("x0_reads_zero", rd1_e, 0);

    // sw, then stall three cycles with a different instruction presented.
    drive(32'h00112223, 1, 0, 0, 0, 5'd0, 32'h0);
    step();
    check("sw_mem_write", mem_write_e, 1);
    check("sw_imm",       imm_ext_e,   4);
    for (int i = 0; i < 3; i++) begin
      drive(32'hFFD00093, 1, 1, 0, 1, 5'd1, 32'hAAAA);
      step();
      check("stall_mem_write", mem_write_e, 1);
      check("stall_imm",       imm_ext_e,   4);
    end
    drive(32'hFFD00093, 1, 1, 1, 0, 5'd0, 32'h0);
    step();
    check("flush_valid",     valid_e,     0);
    check("flush_mem_write", mem_write_e, 0);

    // Unknown opcode.
    drive(32'h0000007F, 1, 0, 0, 0, 5'd0, 32'h0);
    step();
    check("badop_illegal",   illegal_e,   1);
    check("badop_reg_write", reg_write_e, 0);
    check("badop_valid",     valid_e,     1);

    // x20 exists only on the 32-register instance.
    drive(32'h00000013, 1, 0, 0, 1, 5'd20, 32'h777);
    step();
    drive(32'h000A00B3, 1, 0, 0, 0, 5'd0, 32'h0);
    step();
    check("rv32e_illegal", illegal_e2, 1);
    check("rv32e_rd1",     rd1_e2,     0);
    check("rv32e_regw",    reg_write_e2, 0);
    check("rv32i_legal",   illegal_e,  0);
    check("rv32i_rd1",     rd1_e,      32'h777);

    // Immediate formats.
    drive(32'hFE000CE3, 1, 0, 0, 0, 5'd0, 32'h0);
    step();
    check("beq_imm",    imm_ext_e,     32'hFFFFFFF8);
    check("beq_branch", branch_e,      1);
    check("beq_alu",    alu_control_e, 3'b001);
    drive(32'h001000EF, 1, 0, 0, 0, 5'd0, 32'h0);
    step();
    check("jal_imm",  imm_ext_e,    32'h800);
    check("jal_rsrc", result_src_e, 2'b10);
    check("jal_jump", jump_e,       1);
    drive(32'hABCDE2B7, 1, 0, 0, 0, 5'd0, 32'h0);
    step();
    check("lui_imm",    imm_ext_e,  32'hABCDE000);
    check("lui_rs1",    rs1_e,      0);
    check("lui_imm_64", imm_ext_e2, 64'hFFFFFFFFABCDE000);

    // Random traffic.
    for (int t = 0; t < 300; t++) begin
      drive(gen_instr(), ($urandom_range(0, 9) != 0), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 11) == 0), $urandom_range(0, 1),
            5'($urandom_range(0, 31)), $urandom);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule

// File: doc/decode_stage_hz.md
Name: decode_stage_hz

Overview:
- Parametrised instruction-decode stage for the pipelined RISC-V core.
- Contains the integrated register file with WB write-through bypass, the control decoder, the five-format immediate generator and the ID/EX pipeline register.
- Adds stall (hold), flush (bubble), valid tracking, illegal-instruction flagging and XLEN/register-count generality.
- Sits between the fetch stage (IF/ID outputs) and the execute stage; hazard-unit controls drive stall_d and flush_e.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- NREGS, 32, architectural registers; legal values 32 or 16 (RV32E).

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- stall_d  in  1  hold ID/EX register contents
- flush_e  in  1  load a bubble into ID/EX
- valid_d  in  1  instr_d holds a real instruction
- instr_d  in  32  instruction word
- pc_d  in  XLEN  instruction PC
- pc_plus4_d  in  XLEN  PC+4
- reg_write_w  in  1  writeback enable
- rd_w  in  5  writeback destination
- result_w  in  XLEN  writeback data
- valid_e  out  1  ID/EX holds a real instruction
- reg_write_e, alu_src_e, mem_write_e, branch_e, jump_e  out  1 each  control
- result_src_e  out  2  00 ALU, 01 memory, 10 PC+4
- alu_control_e  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- illegal_e  out  1  undecodable opcode/funct or register index >= NREGS
- rd1_e, rd2_e, imm_ext_e, pc_e, pc_plus4_e  out  XLEN each  data
- rd_e, rs1_e, rs2_e  out  5 each  register indices

Behaviour:
- Reset (async, rst=1): every output 0; all NREGS registers 0. Deassertion takes effect at the next clk edge.
- ID/EX update priority: rst > flush_e > stall_d > load.
  - flush_e: every ID/EX field is cleared to 0, so valid_e=0 and all controls are 0.
  - stall_d (without flush_e): all fields hold.
  - load: fields capture the decode results. Latency is 1 cycle from instr_d to the *_e outputs.
- valid_d=0 on load: identical to flush (bubble).
- illegal: valid_e=1 and illegal_e=1, with all side-effect controls forced to 0 (reg_write, mem_write, branch, jump).
- Register file:
  - Written on clk when reg_write_w=1 and rd_w!=0 and rd_w<NREGS.
  - Writes happen independently of stall_d and flush_e.
  - x0 always reads 0.
  - An index >= NREGS reads 0 and sets illegal for that instruction.
- Bypass: if reg_write_w=1, rd_w!=0 and rd_w equals rs1 (or rs2), that read port returns result_w in the same cycle. The new value is therefore captured into ID/EX on the edge that also writes the register.
- Fields captured on load:
  - rs1 = instr[19:15], rs2 = instr[24:20], rd = instr[11:7].
  - For lui, rs1 is forced to 0.
- Decode (opcode -> reg_write, alu_src, mem_write, result_src, branch, jump, alu_control):
  - 0000011 lw: 1,1,0,01,0,0,add; immediate I.
  - 0100011 sw: 0,1,1,00,0,0,add; immediate S.
  - 0110011 R: 1,0,0,00,0,0,funct; no immediate.
  - 0010011 I-ALU: 1,1,0,00,0,0,funct; immediate I.
  - 1100011 beq: 0,0,0,00,1,0,sub; immediate B; funct3 must be 000, else illegal.
  - 1101111 jal: 1,x,0,10,0,1,add; immediate J.
  - 0110111 lui: 1,1,0,00,0,0,add; immediate U.
  - Any other opcode: illegal.
- funct decode for R and I-ALU:
  - funct3 000: add, or sub when R-type and funct7[5]=1.
  - funct3 010: slt; 110: or; 111: and.
  - Any other funct3: illegal.
  - R-type requires funct7 to be 0000000, or 0100000 only for funct3 000; any other funct7 is illegal.
- Immediates, each sign-extended from instr[31] to XLEN:
  - I = instr[31:20].
  - S = {instr[31:25], instr[11:7]}.
  - B = {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - J = {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - U = {instr[31:12], 12'b0}.
  - imm_ext_e = 0 for R-type.
- Simultaneous events:
  - flush_e together with stall_d: flush wins.
  - A register write during stall_d does not update the held rd1_e/rd2_e. The hazard unit re-issues the instruction.
- Reset mid-stall: all state clears immediately; the stall is released.

Test Plan:
- Reset: rst=1 with writes pending -> every output 0; a subsequent read of x5 returns 0.
- addi x1,x0,-3 (0xFFD00093), valid_d=1 -> next cycle reg_write_e=1, alu_src_e=1, imm_ext_e=0xFFFFFFFD, rd_e=1, alu_control_e=000, valid_e=1.
- Bypass: reg_write_w=1, rd_w=2, result_w=0x1234 while decoding add x3,x2,x2 (0x002101B3) -> rd1_e=rd2_e=0x1234. Writing x0 with 0xFF -> later reads of x0 return 0.
- Stall then flush: load sw (0x00112223), assert stall_d for 3 cycles with a new instruction on instr_d -> outputs hold mem_write_e=1, imm_ext_e=4. Then assert flush_e together with stall_d -> valid_e=0, mem_write_e=0.
- Illegal: opcode 0x7F -> illegal_e=1, reg_write_e=0. With NREGS=16, add x1,x20,x0 -> illegal_e=1 and rd1_e=0.
- Immediate formats: beq with offset -8 -> imm_ext_e=0xFFFFFFF8, branch_e=1, alu_control_e=001. jal +2048 -> imm_ext_e=0x800, result_src_e=10. lui 0xABCDE -> imm_ext_e=0xABCDE000, rs1_e=0. With XLEN=64, the same lui -> 0xFFFFFFFFABCDE000.
